program_loader: RTL and testbench

Writer side of the CPU program store: an 8-entry x 10-bit program RAM that the operator fills from the 4-bit switches, one nibble per press of the enter button.
- The CPU reads the same RAM through a combinational read port addressed by its pc.
- Replaces the hard-wired program array.
- Holds the CPU while loading is in progress.

---
 rtl/program_loader_if.sv | 26 ++
 rtl/program_loader.sv | 107 ++++++++++
 tb/tb_program_loader.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_if.sv
// Operator/CPU-facing signals of the program loader: switch entry, load control,
// the CPU read port and the loader's status outputs.
interface program_loader_if #(
  parameter int ADDR_BITS = 3,
  parameter int STMT_BITS = 10
);
  logic                 load_mode;
  logic                 enter;
  logic [3:0]           data_in;
  logic [ADDR_BITS-1:0] rd_addr;
  logic [STMT_BITS-1:0] rd_stmt;
  logic                 cpu_hold;
  logic [ADDR_BITS-1:0] wr_addr;
  logic [1:0]           phase;
  logic                 full;

  modport master (
    output load_mode, enter, data_in, rd_addr,
    input  rd_stmt, cpu_hold, wr_addr, phase, full
  );

  modport slave (
    input  load_mode, enter, data_in, rd_addr,
    output rd_stmt, cpu_hold, wr_addr, phase, full
  );
endinterface

// File: rtl/program_loader.sv
// Program RAM writer: assembles {opcode[5:0], arg[3:0]} statements from three switch
// nibbles per statement and exposes a combinational read port to the CPU.
module program_loader #(
  parameter int ADDR_BITS = 3,
  parameter int STMT_BITS = 10
) (
  input  logic                 oneMHzClock,
  input  logic                 reset_n,
  program_loader_if.slave      bus
);

  localparam int                   DEPTH = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] LAST  = ADDR_BITS'(DEPTH - 1);

  typedef enum logic [1:0] {
    PH_HI  = 2'd0,
    PH_LO  = 2'd1,
    PH_ARG = 2'd2
  } phase_t;

  phase_t                 phase_q, phase_d;
  logic                   enter_q;
  logic                   cpu_hold_q;
  logic [5:0]             partial_q;
  logic [ADDR_BITS-1:0]   wr_addr_q;
  logic                   full_q;
  logic [STMT_BITS-1:0]   ram [DEPTH];

  logic press;
  logic mode_entry;
  logic take_hi;
  logic take_lo;
  logic write_en;

  assign press      = bus.enter & ~enter_q & bus.load_mode;
  // cpu_hold still low while load_mode is high marks the first cycle of a load session.
  assign mode_entry = bus.load_mode & ~cpu_hold_q;

  // NOTE: sequential state uses <= so every flop samples pre-edge values; = here would
  // create order-dependent simulation and mismatch the synthesized netlist.
  always_ff @(posedge oneMHzClock or negedge reset_n) begin
    if (!reset_n) begin
      enter_q    <= 1'b0;
      cpu_hold_q <= 1'b0;
      phase_q    <= PH_HI;
    end else begin
      enter_q    <= bus.enter;
      cpu_hold_q <= bus.load_mode;
      phase_q    <= phase_d;
    end
  end

  // NOTE: every output of this block gets a default first, otherwise paths that skip an
  // assignment infer latches.
  always_comb begin
    phase_d  = phase_q;
    take_hi  = 1'b0;
    take_lo  = 1'b0;
    write_en = 1'b0;
    if (!bus.load_mode || mode_entry) begin
      phase_d = PH_HI;
    end else if (press) begin
      case (phase_q)
        PH_HI:  begin phase_d = PH_LO;  take_hi  = 1'b1; end
        PH_LO:  begin phase_d = PH_ARG; take_lo  = 1'b1; end
        PH_ARG: begin phase_d = PH_HI;  write_en = 1'b1; end
        default: phase_d = PH_HI;
      endcase
    end
  end

  always_ff @(posedge oneMHzClock or negedge reset_n) begin
    if (!reset_n) begin
      partial_q <= '0;
      wr_addr_q <= '0;
      full_q    <= 1'b0;
    end else if (mode_entry) begin
      partial_q <= '0;
      wr_addr_q <= '0;
      full_q    <= 1'b0;
    end else begin
      if (take_hi) partial_q[5:4] <= bus.data_in[1:0];
      if (take_lo) partial_q[3:0] <= bus.data_in;
      if (write_en) begin
        if (wr_addr_q == LAST) full_q <= 1'b1;
        wr_addr_q <= wr_addr_q + 1'b1;
      end
    end
  end

  // NOTE: the RAM is built from resettable flops because reset must clear every word
  // asynchronously; a block-RAM style array without reset could not do that.
  always_ff @(posedge oneMHzClock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= '0;
    end else if (write_en) begin
      ram[wr_addr_q] <= STMT_BITS'({partial_q, bus.data_in});
    end
  end

  assign bus.rd_stmt  = ram[bus.rd_addr];
  assign bus.cpu_hold = cpu_hold_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.phase    = phase_q;
  assign bus.full     = full_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: a scoreboard queue carries each expected RAM
// write from the cycle its final nibble is driven to the edge the word appears.
`timescale 1ns/1ps
module tb_program_loader;

  typedef struct packed {
    logic [2:0] addr;
    logic [9:0] stmt;
  } wr_t;

  logic clk;
  logic reset_n;
  int   errors;
  int   checks;

  wr_t        sb_q[$];
  logic [9:0] exp_ram [8];
  logic [2:0] m_wr;
  logic       m_full;

  program_loader_if #(.ADDR_BITS(3), .STMT_BITS(10)) bus ();

  program_loader #(.ADDR_BITS(3), .STMT_BITS(10)) dut (
    .oneMHzClock (clk),
    .reset_n     (reset_n),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #500 clk = ~clk;

  task automatic press_nibble(input logic [3:0] d);
    @(negedge clk);
    bus.data_in = d;
    bus.enter   = 1'b1;
    @(negedge clk);
    bus.enter   = 1'b0;
  endtask

  task automatic enter_mode();
    @(negedge clk);
    bus.load_mode = 1'b1;
    @(negedge clk);
    m_wr   = 3'd0;
    m_full = 1'b0;
    checks++;
    if (bus.cpu_hold !== 1'b1 || bus.phase !== 2'd0 || bus.wr_addr !== 3'd0 || bus.full !== 1'b0) begin
      errors++;
      $display("FAIL mode_entry: hold=%b phase=%0d wr_addr=%0d full=%b, required 1/0/0/0",
               bus.cpu_hold, bus.phase, bus.wr_addr, bus.full);
    end
  endtask

  task automatic load_stmt(input logic [3:0] n0, input logic [3:0] n1, input logic [3:0] n2);
    wr_t item;
    press_nibble(n0);
    press_nibble(n1);
    @(negedge clk);
    bus.data_in = n2;
    bus.enter   = 1'b1;
    bus.rd_addr = m_wr;
    #1;
    checks++;
    if (bus.rd_stmt !== exp_ram[m_wr]) begin
      errors++;
      $display("FAIL pre_write_read[%0d]: got %h, required old %h", m_wr, bus.rd_stmt, exp_ram[m_wr]);
    end
    sb_q.push_back('{addr: m_wr, stmt: {n0[1:0], n1, n2}});
    @(posedge clk);
    #1;
    item = sb_q.pop_front();
    bus.rd_addr = item.addr;
    #1;
    checks++;
    if (bus.rd_stmt !== item.stmt) begin
      errors++;
      $display("FAIL write_word[%0d]: got %h, required %h", item.addr, bus.rd_stmt, item.stmt);
    end
    exp_ram[item.addr] = item.stmt;
    if (m_wr == 3'd7) m_full = 1'b1;
    m_wr = m_wr + 3'd1;
    checks++;
    if (bus.wr_addr !== m_wr || bus.phase !== 2'd0 || bus.full !== m_full) begin
      errors++;
      $display("FAIL post_write: wr_addr=%0d phase=%0d full=%b, required %0d/0/%b",
               bus.wr_addr, bus.phase, bus.full, m_wr, m_full);
    end
    @(negedge clk);
    bus.enter = 1'b0;
  endtask

  task automatic test_reset();
    #10;
    checks++;
    if (bus.wr_addr !== 3'd0 || bus.phase !== 2'd0 || bus.full !== 1'b0 || bus.cpu_hold !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: wr_addr=%0d phase=%0d full=%b hold=%b, required 0/0/0/0",
               bus.wr_addr, bus.phase, bus.full, bus.cpu_hold);
    end
    for (int a = 0; a < 8; a++) begin
      bus.rd_addr = 3'(a);
      #1;
      checks++;
      if (bus.rd_stmt !== 10'h000) begin
        errors++;
        $display("FAIL reset_ram[%0d]: got %h, required 000", a, bus.rd_stmt);
      end
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.cpu_hold !== 1'b0 || bus.phase !== 2'd0) begin
      errors++;
      $display("FAIL idle_after_reset: hold=%b phase=%0d, required 0/0", bus.cpu_hold, bus.phase);
    end
  endtask

  task automatic test_basic();
    enter_mode();
    load_stmt(4'h2, 4'h0, 4'h1);
    bus.rd_addr = 3'd0;
    #1;
    checks++;
    if (bus.rd_stmt !== 10'h201) begin
      errors++;
      $display("FAIL basic_word: got %h, required 201", bus.rd_stmt);
    end
  endtask

  task automatic test_held_enter();
    int bad;
    bad = 0;
    @(negedge clk);
    bus.data_in = 4'h1;
    bus.enter   = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (bus.phase !== 2'd1) bad++;
    end
    bus.enter = 1'b0;
    @(negedge clk);
    checks++;
    if (bad != 0 || bus.phase !== 2'd1 || bus.wr_addr !== 3'd1) begin
      errors++;
      $display("FAIL held_enter: bad_cycles=%0d phase=%0d wr_addr=%0d, required 0/1/1",
               bad, bus.phase, bus.wr_addr);
    end
    @(negedge clk);
    bus.load_mode = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.phase !== 2'd0 || bus.wr_addr !== 3'd1 || bus.cpu_hold !== 1'b0) begin
      errors++;
      $display("FAIL leave_mode: phase=%0d wr_addr=%0d hold=%b, required 0/1/0",
               bus.phase, bus.wr_addr, bus.cpu_hold);
    end
  endtask

  task automatic test_abandon();
    enter_mode();
    press_nibble(4'h1);
    press_nibble(4'hA);
    checks++;
    if (bus.phase !== 2'd2) begin
      errors++;
      $display("FAIL partial_phase: got %0d, required 2", bus.phase);
    end
    @(negedge clk);
    bus.load_mode = 1'b0;
    #1;
    checks++;
    if (bus.cpu_hold !== 1'b1) begin
      errors++;
      $display("FAIL hold_lag: got %b, required 1", bus.cpu_hold);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.cpu_hold !== 1'b0 || bus.phase !== 2'd0 || bus.wr_addr !== 3'd0) begin
        errors++;
        $display("FAIL run_mode[%0d]: hold=%b phase=%0d wr_addr=%0d, required 0/0/0",
                 i, bus.cpu_hold, bus.phase, bus.wr_addr);
      end
      bus.data_in = 4'h7;
      bus.enter   = (i == 0);
    end
    bus.rd_addr = 3'd0;
    #1;
    checks++;
    if (bus.rd_stmt !== exp_ram[0] || bus.phase !== 2'd0) begin
      errors++;
      $display("FAIL run_mode_no_write: word=%h phase=%0d, required %h/0", bus.rd_stmt, bus.phase, exp_ram[0]);
    end
    enter_mode();
    load_stmt(4'h3, 4'hF, 4'hF);
    bus.rd_addr = 3'd0;
    #1;
    checks++;
    if (bus.rd_stmt !== 10'h3FF) begin
      errors++;
      $display("FAIL abandon_word: got %h, required 3ff", bus.rd_stmt);
    end
  endtask

  task automatic test_press_on_entry();
    @(negedge clk);
    bus.load_mode = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.load_mode = 1'b1;
    bus.enter     = 1'b1;
    bus.data_in   = 4'h3;
    @(negedge clk);
    m_wr   = 3'd0;
    m_full = 1'b0;
    checks++;
    if (bus.phase !== 2'd0 || bus.wr_addr !== 3'd0 || bus.cpu_hold !== 1'b1) begin
      errors++;
      $display("FAIL press_on_entry: phase=%0d wr_addr=%0d hold=%b, required 0/0/1",
               bus.phase, bus.wr_addr, bus.cpu_hold);
    end
    @(negedge clk);
    bus.enter = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.phase !== 2'd0) begin
      errors++;
      $display("FAIL entry_press_held: phase=%0d, required 0", bus.phase);
    end
  endtask

  task automatic test_fill_wrap();
    for (int i = 0; i < 8; i++) begin
      load_stmt(4'h0, 4'h0, 4'(i));
      if (i == 6) begin
        checks++;
        if (bus.full !== 1'b0) begin
          errors++;
          $display("FAIL full_early: got %b, required 0", bus.full);
        end
      end
    end
    checks++;
    if (bus.full !== 1'b1 || bus.wr_addr !== 3'd0) begin
      errors++;
      $display("FAIL full_set: full=%b wr_addr=%0d, required 1/0", bus.full, bus.wr_addr);
    end
    load_stmt(4'h3, 4'hF, 4'hF);
    bus.rd_addr = 3'd1;
    #1;
    checks++;
    if (bus.rd_stmt !== 10'h001 || bus.full !== 1'b1 || bus.wr_addr !== 3'd1) begin
      errors++;
      $display("FAIL wrap: word1=%h full=%b wr_addr=%0d, required 001/1/1",
               bus.rd_stmt, bus.full, bus.wr_addr);
    end
  endtask

  task automatic test_async_reset();
    press_nibble(4'h2);
    @(negedge clk);
    #137;
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.wr_addr !== 3'd0 || bus.phase !== 2'd0 || bus.full !== 1'b0 || bus.cpu_hold !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: wr_addr=%0d phase=%0d full=%b hold=%b, required 0/0/0/0",
               bus.wr_addr, bus.phase, bus.full, bus.cpu_hold);
    end
    for (int a = 0; a < 8; a++) begin
      bus.rd_addr = 3'(a);
      #1;
      checks++;
      if (bus.rd_stmt !== 10'h000) begin
        errors++;
        $display("FAIL async_reset_ram[%0d]: got %h, required 000", a, bus.rd_stmt);
      end
    end
    #291;
    reset_n = 1'b1;
    for (int a = 0; a < 8; a++) exp_ram[a] = 10'h000;
    m_wr   = 3'd0;
    m_full = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.cpu_hold !== 1'b1 || bus.phase !== 2'd0) begin
      errors++;
      $display("FAIL reentry_after_reset: hold=%b phase=%0d, required 1/0", bus.cpu_hold, bus.phase);
    end
    load_stmt(4'h0, 4'h1, 4'h2);
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    reset_n       = 1'b0;
    bus.load_mode = 1'b0;
    bus.enter     = 1'b0;
    bus.data_in   = 4'h0;
    bus.rd_addr   = 3'd0;
    m_wr          = 3'd0;
    m_full        = 1'b0;
    for (int a = 0; a < 8; a++) exp_ram[a] = 10'h000;

    test_reset();
    test_basic();
    test_held_enter();
    test_abandon();
    test_press_on_entry();
    test_fill_wrap();
    test_async_reset();

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
